// File: rtl/johnson_phase_decoder.sv
// Johnson (twisted-ring) word decoder: registered phase index, one-hot phase,
// legality and step checking, revolution counting with sticky error flags.
module johnson_phase_decoder #(
  parameter int WIDTH = 4,
  parameter int REV_W = 8,
  localparam int P     = 2 * WIDTH,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             err_clr,
  output logic [IDX_W-1:0] phase_idx,
  output logic [P-1:0]     phase_onehot,
  output logic             legal,
  output logic             wrap_pulse,
  output logic [REV_W-1:0] rev_count,
  output logic             err_code,
  output logic             err_skip
);

  logic [IDX_W-1:0] phase_idx_q,    phase_idx_d;
  logic [P-1:0]     phase_onehot_q, phase_onehot_d;
  logic             legal_q,        legal_d;
  logic             wrap_pulse_q,   wrap_pulse_d;
  logic [REV_W-1:0] rev_count_q,    rev_count_d;
  logic             err_code_q,     err_code_d;
  logic             err_skip_q,     err_skip_d;
  logic             prev_valid_q,   prev_valid_d;

  logic [WIDTH-2:0] edge_w;
  logic [IDX_W-1:0] ones_cnt;
  logic [IDX_W-1:0] edge_cnt;
  logic             code_ok;
  logic [IDX_W-1:0] idx_dec;
  logic [P-1:0]     onehot_dec;
  logic [IDX_W-1:0] next_of_prev;
  logic             step_ok;
  logic             new_code_err;
  logic             new_skip_err;

  // A legal Johnson word has at most one boundary between adjacent bits.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edge
      assign edge_w[gi] = jc_in[gi] ^ jc_in[gi+1];
    end
  endgenerate

  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + IDX_W'(jc_in[i]);
    end
  end

  always_comb begin
    edge_cnt = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      edge_cnt = edge_cnt + IDX_W'(edge_w[i]);
    end
  end

  assign code_ok = (edge_cnt <= IDX_W'(1));

  // Filling half (ones at LSB end) counts up; draining half counts down from P.
  always_comb begin
    if (jc_in[0] || (ones_cnt == '0)) begin
      idx_dec = ones_cnt;
    end else begin
      idx_dec = IDX_W'(P - int'(ones_cnt));
    end
  end

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_onehot
      assign onehot_dec[gi] = (idx_dec == IDX_W'(gi));
    end
  endgenerate

  assign next_of_prev = (phase_idx_q == IDX_W'(P - 1)) ? '0 : phase_idx_q + IDX_W'(1);
  assign step_ok      = (idx_dec == phase_idx_q) || (idx_dec == next_of_prev);

  always_comb begin
    phase_idx_d    = phase_idx_q;
    phase_onehot_d = phase_onehot_q;
    legal_d        = legal_q;
    wrap_pulse_d   = 1'b0;
    rev_count_d    = rev_count_q;
    prev_valid_d   = prev_valid_q;
    new_code_err   = 1'b0;
    new_skip_err   = 1'b0;

    if (en) begin
      if (code_ok) begin
        phase_idx_d    = idx_dec;
        phase_onehot_d = onehot_dec;
        legal_d        = 1'b1;
        prev_valid_d   = 1'b1;
        if (prev_valid_q) begin
          new_skip_err = ~step_ok;
          if ((phase_idx_q == IDX_W'(P - 1)) && (idx_dec == '0)) begin
            wrap_pulse_d = 1'b1;
            rev_count_d  = rev_count_q + REV_W'(1);
          end
        end
      end else begin
        // Phase index holds; the next legal code starts a fresh run.
        phase_onehot_d = '0;
        legal_d        = 1'b0;
        prev_valid_d   = 1'b0;
        new_code_err   = 1'b1;
      end
    end

    err_code_d = new_code_err | (err_code_q & ~err_clr);
    err_skip_d = new_skip_err | (err_skip_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_idx_q    <= '0;
      phase_onehot_q <= '0;
      legal_q        <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      rev_count_q    <= '0;
      err_code_q     <= 1'b0;
      err_skip_q     <= 1'b0;
      prev_valid_q   <= 1'b0;
    end else begin
      phase_idx_q    <= phase_idx_d;
      phase_onehot_q <= phase_onehot_d;
      legal_q        <= legal_d;
      wrap_pulse_q   <= wrap_pulse_d;
      rev_count_q    <= rev_count_d;
      err_code_q     <= err_code_d;
      err_skip_q     <= err_skip_d;
      prev_valid_q   <= prev_valid_d;
    end
  end

  assign phase_idx    = phase_idx_q;
  assign phase_onehot = phase_onehot_q;
  assign legal        = legal_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign rev_count    = rev_count_q;
  assign err_code     = err_code_q;
  assign err_skip     = err_skip_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed scenarios plus randomized walks
// compared against a table-driven phase model.
module tb_johnson_phase_decoder;
  localparam int W  = 4;
  localparam int RW = 8;
  localparam int P  = 2 * W;
  localparam int IW = $clog2(P);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [W-1:0]  jc_in = '0;
  logic          err_clr = 1'b0;
  logic [IW-1:0] phase_idx;
  logic [P-1:0]  phase_onehot;
  logic          legal;
  logic          wrap_pulse;
  logic [RW-1:0] rev_count;
  logic          err_code;
  logic          err_skip;

  int checks   = 0;
  int failures = 0;

  // Reference state: phase position within the ring and status flags.
  logic [W-1:0] jtab [P];
  int m_phase, m_rev;
  bit m_legal, m_pv, m_wrap, m_ecode, m_eskip;

  johnson_phase_decoder #(.WIDTH(W), .REV_W(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .jc_in(jc_in), .err_clr(err_clr),
    .phase_idx(phase_idx), .phase_onehot(phase_onehot), .legal(legal),
    .wrap_pulse(wrap_pulse), .rev_count(rev_count), .err_code(err_code),
    .err_skip(err_skip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".phase_idx"}, 32'(phase_idx), 32'(m_phase));
    check({ctx, ".onehot"}, 32'(phase_onehot), m_legal ? (32'd1 << m_phase) : 32'd0);
    check({ctx, ".legal"}, 32'(legal), 32'(m_legal));
    check({ctx, ".wrap"}, 32'(wrap_pulse), 32'(m_wrap));
    check({ctx, ".rev"}, 32'(rev_count), 32'(m_rev));
    check({ctx, ".err_code"}, 32'(err_code), 32'(m_ecode));
    check({ctx, ".err_skip"}, 32'(err_skip), 32'(m_eskip));
  endtask

  task automatic model_reset();
    m_phase = 0; m_rev = 0; m_legal = 0; m_pv = 0;
    m_wrap = 0; m_ecode = 0; m_eskip = 0;
  endtask

  task automatic model_step(input bit e, input logic [W-1:0] jc, input bit clr);
    int k;
    bit nc, ns;
    k = -1; nc = 0; ns = 0; m_wrap = 0;
    if (e) begin
      for (int i = 0; i < P; i++) if (jtab[i] == jc) k = i;
      if (k >= 0) begin
        if (m_pv) begin
          ns = !(k == m_phase || k == (m_phase + 1) % P);
          if (m_phase == P - 1 && k == 0) begin
            m_wrap = 1;
            m_rev  = (m_rev + 1) % (1 << RW);
          end
        end
        m_phase = k; m_legal = 1; m_pv = 1;
      end else begin
        nc = 1; m_legal = 0; m_pv = 0;
      end
    end
    m_ecode = nc | (m_ecode & !clr);
    m_eskip = ns | (m_eskip & !clr);
  endtask

  task automatic step(input string ctx, input bit e, input logic [W-1:0] jc, input bit clr);
    en = e; jc_in = jc; err_clr = clr;
    @(posedge clk);
    model_step(e, jc, clr);
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic async_reset(input string ctx);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(ctx);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] full;
    logic [W-1:0] rj;
    int r;
    full = '1;
    for (int k = 0; k < P; k++) begin
      if (k <= W) jtab[k] = W'((1 << k) - 1);
      else        jtab[k] = full & ~W'((1 << (k - W)) - 1);
    end
    model_reset();

    #2;
    check_all("reset");
    #10 rst = 1'b0;

    // 1: one full revolution from 0000 back to 0000
    for (int k = 0; k <= P; k++) step("rev1", 1, jtab[k % P], 0);
    check("rev1.rev_const", 32'(rev_count), 32'd1);
    check("rev1.wrap_const", 32'(wrap_pulse), 32'd1);

    // 2: illegal code after idx 2, then legal code without jump check
    step("t2a", 1, 4'b0001, 0);
    step("t2b", 1, 4'b0011, 0);
    step("t2c", 1, 4'b0101, 0);
    check("t2.idx_hold", 32'(phase_idx), 32'd2);
    step("t2d", 1, 4'b1111, 0);
    check("t2.no_skip", 32'(err_skip), 32'd0);

    // 3: jump 1 -> 3 sets err_skip; repeat is a stall
    async_reset("t3rst");
    step("t3a", 1, 4'b0001, 0);
    step("t3b", 1, 4'b0111, 0);
    check("t3.skip", 32'(err_skip), 32'd1);
    step("t3c", 1, 4'b0111, 0);

    // 4: en=0 while jc toggles illegal values, then clean advance
    for (int i = 0; i < 3; i++) step("t4hold", 0, (i % 2) ? 4'b0101 : 4'b1010, 0);
    step("t4adv", 1, 4'b1111, 0);

    // 5: clear with a same-edge new error keeps the flag; legal clear drops it
    step("t5a", 1, 4'b1001, 0);
    step("t5b", 1, 4'b0110, 1);
    check("t5.code_kept", 32'(err_code), 32'd1);
    step("t5c", 1, 4'b0000, 1);
    check("t5.code_clr", 32'(err_code), 32'd0);

    // Randomized mix of advances, stalls, jumps, illegal codes, en=0, clears
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99);
      rj = W'($urandom);
      if      (r < 55) step("rnd", 1, jtab[(m_phase + 1) % P], ($urandom_range(0, 9) == 0));
      else if (r < 65) step("rnd", 1, jtab[m_phase], 0);
      else if (r < 73) step("rnd", 1, jtab[$urandom_range(0, P - 1)], 0);
      else if (r < 81) step("rnd", 1, rj, ($urandom_range(0, 3) == 0));
      else if (r < 93) step("rnd", 0, rj, 0);
      else             step("rnd", $urandom_range(0, 1), rj, 1);
    end

    // 6: 256 revolutions wrap rev_count 255 -> 0, then async reset mid-run
    async_reset("t6rst");
    step("t6start", 1, jtab[0], 0);
    for (int rv = 0; rv < 256; rv++) begin
      for (int k = 1; k <= P; k++) step("t6", 1, jtab[k % P], 0);
      if (rv == 254) check("t6.rev255", 32'(rev_count), 32'd255);
    end
    check("t6.rev0", 32'(rev_count), 32'd0);
    step("t6b", 1, jtab[1], 0);
    step("t6c", 1, jtab[2], 0);
    async_reset("t6mid");
    step("t6post", 1, jtab[5], 0);
    check("t6.post_skip", 32'(err_skip), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
